// File: rtl/lcg_stim_pkg.sv
// lcg_stim_pkg: shared constants, types and the LCG step function for lcg_stim_gen.
package lcg_stim_pkg;

  localparam logic [31:0] LCG_MUL = 32'h41C64E6D;
  localparam logic [31:0] LCG_INC = 32'h3039;

  // Encoding 3 is reserved and is folded to ModeRandom when a run is captured
  typedef enum logic [1:0] {
    ModeRandom = 2'd0,
    ModeHold   = 2'd1,
    ModeCount  = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StFill    = 2'd1,
    StPresent = 2'd2,
    StDone    = 2'd3
  } state_e;

  function automatic logic [31:0] lcg_next(input logic [31:0] state);
    return state * LCG_MUL + LCG_INC;
  endfunction

endpackage

// File: rtl/lcg_step.sv
// lcg_step: one combinational step of the harness LCG.
module lcg_step
  import lcg_stim_pkg::*;
(
  input  logic [31:0] state_i,
  output logic [31:0] state_o
);

  assign state_o = lcg_next(state_i);

endmodule

// File: rtl/lcg_stim_gen.sv
// lcg_stim_gen: LCG-driven stimulus vector source with valid/ready delivery.
// Define LCG_STIM_PAR_FILL_EN to fill a whole vector in one cycle with a chain of
// lcg_step instances; otherwise one 32-bit word is produced per cycle.
module lcg_stim_gen
  import lcg_stim_pkg::*;
#(
  parameter int unsigned OUT_W        = 138,
  parameter logic [31:0] SEED_DEFAULT = 32'hE80AD44B
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      seed_i,
  input  logic [31:0]      cycles_i,
  input  logic [1:0]       mode_i,
  input  logic             abort,
  output logic [OUT_W-1:0] vec_o,
  output logic             vec_valid_o,
  input  logic             vec_ready_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [31:0]      vec_count_o,
  output logic [31:0]      lcg_state_o
);

  localparam int unsigned WORDS = (OUT_W + 31) / 32;

  state_e           state_q, state_d;
  mode_e            mode_q, mode_sel;
  logic [31:0]      cycles_q;
  logic [31:0]      count_q, count_inc;
  logic [31:0]      lcg_q, lcg_fill;
  logic [OUT_W-1:0] buf_q, fill_vec;
  logic             done_q;
  logic             fill_last;

  assign mode_sel  = (mode_i == 2'd3) ? ModeRandom : mode_e'(mode_i);
  // No wrap concern: termination is checked before count_q can reach cycles_q
  assign count_inc = count_q + 32'd1;

`ifdef LCG_STIM_PAR_FILL_EN
  logic [31:0] chain [WORDS+1];

  assign chain[0] = lcg_q;
  for (genvar w = 0; w < WORDS; w++) begin : g_chain
    lcg_step u_lcg_step (
      .state_i(chain[w]),
      .state_o(chain[w+1])
    );
  end

  // Slice all chained post-step states into the vector, LSW first
  always_comb begin
    fill_vec = '0;
    for (int b = 0; b < OUT_W; b++) begin
      fill_vec[b] = chain[b / 32 + 1][b % 32];
    end
  end

  assign lcg_fill  = chain[WORDS];
  assign fill_last = 1'b1;
`else
  localparam int unsigned     IDX_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  logic [IDX_W-1:0] idx_q;
  logic [31:0]      step_out;

  lcg_step u_lcg_step (
    .state_i(lcg_q),
    .state_o(step_out)
  );

  // Drop the next LCG word into slot idx_q; the top word truncates naturally
  always_comb begin
    fill_vec = buf_q;
    for (int b = 0; b < OUT_W; b++) begin
      if (IDX_W'(b / 32) == idx_q) fill_vec[b] = step_out[b % 32];
    end
  end

  assign lcg_fill  = step_out;
  assign fill_last = (idx_q == LAST_IDX);

  // Word index walks 0..WORDS-1 during a RANDOM/HOLD fill, idles at zero otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else if (abort || state_q != StFill || mode_q == ModeCount || fill_last) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_q + IDX_W'(1);
    end
  end
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; abort overrides start and any same-cycle handshake
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) state_d = (cycles_i == '0) ? StDone : StFill;
        end
        StFill: begin
          if (mode_q == ModeCount || fill_last) state_d = StPresent;
        end
        StPresent: begin
          if (vec_ready_i) begin
            if (count_inc == cycles_q) begin
              state_d = StDone;
            end else if (mode_q != ModeHold) begin
              state_d = StFill;
            end
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Run context, LCG state, vector buffer, counter and done flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lcg_q    <= SEED_DEFAULT;
      buf_q    <= '0;
      count_q  <= '0;
      cycles_q <= '0;
      mode_q   <= ModeRandom;
      done_q   <= 1'b0;
    end else if (!abort) begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            lcg_q    <= seed_i;
            cycles_q <= cycles_i;
            mode_q   <= mode_sel;
            count_q  <= '0;
            done_q   <= 1'b0;
          end
        end
        StFill: begin
          if (mode_q == ModeCount) begin
            buf_q <= OUT_W'(count_q);
          end else begin
            buf_q <= fill_vec;
            lcg_q <= lcg_fill;
          end
        end
        StPresent: begin
          if (vec_ready_i) count_q <= count_inc;
        end
        StDone:  done_q <= 1'b1;
        default: ;
      endcase
    end
  end

  // Outputs decoded from state and registers
  always_comb begin
    vec_o       = buf_q;
    vec_valid_o = (state_q == StPresent);
    busy_o      = (state_q == StFill) || (state_q == StPresent);
    done_o      = done_q;
    vec_count_o = count_q;
    lcg_state_o = lcg_q;
  end

endmodule

// File: tb/tb_lcg_stim_gen.sv
// tb_lcg_stim_gen: table-driven runs with a scoreboard of expected vectors, plus
// hand-written sequences for latency, zero-length runs, abort and mid-run reset.
module tb_lcg_stim_gen;

  localparam int WORDS = 5;
`ifdef LCG_STIM_PAR_FILL_EN
  localparam int FIRST_LAT = 2;
  localparam int THRU      = 2;
`else
  localparam int FIRST_LAT = WORDS + 1;
  localparam int THRU      = WORDS + 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start, abort, vec_ready_i;
  logic [31:0]  seed_i, cycles_i;
  logic [1:0]   mode_i;
  logic [137:0] vec_o;
  logic         vec_valid_o, busy_o, done_o;
  logic [31:0]  vec_count_o, lcg_state_o;
  logic [47:0]  vec48;
  logic         valid48, busy48, done48;
  logic [31:0]  count48, lcg48;

  lcg_stim_gen dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed_i(seed_i), .cycles_i(cycles_i),
    .mode_i(mode_i), .abort(abort), .vec_o(vec_o), .vec_valid_o(vec_valid_o),
    .vec_ready_i(vec_ready_i), .busy_o(busy_o), .done_o(done_o),
    .vec_count_o(vec_count_o), .lcg_state_o(lcg_state_o)
  );

  lcg_stim_gen #(.OUT_W(48)) dut48 (
    .clk(clk), .rst_n(rst_n), .start(start), .seed_i(seed_i), .cycles_i(cycles_i),
    .mode_i(mode_i), .abort(abort), .vec_o(vec48), .vec_valid_o(valid48),
    .vec_ready_i(vec_ready_i), .busy_o(busy48), .done_o(done48),
    .vec_count_o(count48), .lcg_state_o(lcg48)
  );

  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_pass = 0;
  int           hs_cnt = 0;
  int           ready_pct = 100;
  logic [137:0] sb[$];
  logic [31:0]  exp_lcg;

  typedef struct {
    logic [31:0] seed;
    logic [31:0] cycles;
    logic [1:0]  mode;
    int          ready_pct;
    logic [31:0] exp_count;
  } row_t;
  row_t rows[6];

  task automatic chk(input string name, input logic [137:0] act, input logic [137:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] lcg_f(input logic [31:0] s);
    return s * 32'h41C64E6D + 32'h3039;
  endfunction

  task automatic model_vec(inout logic [31:0] s, output logic [137:0] v);
    logic [159:0] w;
    for (int i = 0; i < WORDS; i++) begin
      s = lcg_f(s);
      w[32*i +: 32] = s;
    end
    v = w[137:0];
  endtask

  // Queue every vector the run should deliver and record the final LCG state
  task automatic push_expected(input logic [31:0] s, input logic [31:0] c, input logic [1:0] m);
    logic [31:0]  st;
    logic [137:0] v;
    st = s;
    v  = '0;
    for (int unsigned k = 0; k < c; k++) begin
      if (m == 2'd2) v = 138'(k);
      else if (m == 2'd1) begin
        if (k == 0) model_vec(st, v);
      end else model_vec(st, v);
      sb.push_back(v);
    end
    exp_lcg = st;
  endtask

  task automatic start_run(input logic [31:0] s, input logic [31:0] c, input logic [1:0] m);
    seed_i = s; cycles_i = c; mode_i = m; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (!done_o && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, 138'(done_o), 138'd1);
  endtask

  // Randomised backpressure
  initial begin
    vec_ready_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      vec_ready_i = ($urandom_range(0, 99) < ready_pct);
    end
  end

  // Scoreboard and stability monitor, sampled on the falling edge
  initial begin
    logic         held_valid;
    logic [137:0] held_vec;
    held_valid = 1'b0;
    held_vec   = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held_valid = 1'b0;
      end else begin
        if (held_valid) begin
          chk("valid_held", 138'(vec_valid_o), 138'd1);
          if (vec_valid_o) chk("vec_stable", vec_o, held_vec);
        end
        held_valid = 1'b0;
        if (vec_valid_o && !abort) begin
          if (vec_ready_i) begin
            hs_cnt++;
            if (sb.size() == 0) begin
              n_checks++;
              $display("FAIL sb_underflow: got extra vector 0x%0h, expected none", vec_o);
            end else begin
              chk("vec_data", vec_o, sb.pop_front());
            end
          end else begin
            held_valid = 1'b1;
            held_vec   = vec_o;
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before 1ms");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rows[0] = '{32'hE80AD44B, 32'd200, 2'd0, 100, 32'd200};
    rows[1] = '{32'h12345678, 32'd20,  2'd0, 50,  32'd20};
    rows[2] = '{32'h00000007, 32'd5,   2'd1, 100, 32'd5};
    rows[3] = '{32'h00000009, 32'd3,   2'd2, 100, 32'd3};
    rows[4] = '{32'h00000055, 32'd4,   2'd3, 50,  32'd4};
    rows[5] = '{32'h00000001, 32'd6,   2'd1, 50,  32'd6};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    seed_i = '0; cycles_i = '0; mode_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vec", vec_o, 138'd0);
    chk("rst_valid", 138'(vec_valid_o), 138'd0);
    chk("rst_busy", 138'(busy_o), 138'd0);
    chk("rst_done", 138'(done_o), 138'd0);
    chk("rst_count", 138'(vec_count_o), 138'd0);
    chk("rst_lcg", 138'(lcg_state_o), 138'hE80AD44B);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Seed 0, one vector: known 48-bit answer
    push_expected(32'd0, 32'd1, 2'd0);
    start_run(32'd0, 32'd1, 2'd0);
    wait_done(100, "w48_done");
    chk("w48_vec", 138'(vec48), 138'h167E_00003039);
    chk("w48_count", 138'(count48), 138'd1);
    chk("w48_done_lvl", 138'(done48), 138'd1);
    chk("w48_lcg", 138'(lcg48), 138'hD3DC167E);
    chk("w138_lcg", 138'(lcg_state_o), 138'(exp_lcg));

    // Latency to first valid and serial throughput
    push_expected(32'hCAFEF00D, 32'd2, 2'd0);
    start_run(32'hCAFEF00D, 32'd2, 2'd0);
    chk("busy_rise", 138'(busy_o), 138'd1);
    chk("done_clr", 138'(done_o), 138'd0);
    n = 1;
    while (!vec_valid_o && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("first_lat", 138'(n), 138'(FIRST_LAT));
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!vec_valid_o && n < 20);
    chk("throughput", 138'(n), 138'(THRU));
    wait_done(40, "lat_done");
    chk("lat_count", 138'(vec_count_o), 138'd2);

    // Zero-length run
    start_run(32'd11, 32'd0, 2'd0);
    chk("zero_done_e1", 138'(done_o), 138'd0);
    chk("zero_busy", 138'(busy_o), 138'd0);
    @(posedge clk); #1;
    chk("zero_done_e2", 138'(done_o), 138'd1);
    chk("zero_count", 138'(vec_count_o), 138'd0);

    for (int r = 0; r < 6; r++) begin
      ready_pct = rows[r].ready_pct;
      hs_cnt = 0;
      push_expected(rows[r].seed, rows[r].cycles, rows[r].mode);
      start_run(rows[r].seed, rows[r].cycles, rows[r].mode);
      wait_done(int'(rows[r].cycles) * 40 + 50, $sformatf("row%0d_done", r));
      chk($sformatf("row%0d_count", r), 138'(vec_count_o), 138'(rows[r].exp_count));
      chk($sformatf("row%0d_hs", r), 138'(hs_cnt), 138'(rows[r].exp_count));
      chk($sformatf("row%0d_lcg", r), 138'(lcg_state_o), 138'(exp_lcg));
      chk($sformatf("row%0d_sb_left", r), 138'(sb.size()), 138'd0);
    end

    // Abort during the third PRESENT with ready high
    ready_pct = 100;
    @(posedge clk); #1;
    push_expected(32'h0000ABCD, 32'd5, 2'd0);
    start_run(32'h0000ABCD, 32'd5, 2'd0);
    n = 0;
    while (!(vec_valid_o && vec_count_o == 32'd2) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("abort_reach", 138'(vec_valid_o), 138'd1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_valid", 138'(vec_valid_o), 138'd0);
    chk("abort_count", 138'(vec_count_o), 138'd2);
    chk("abort_done", 138'(done_o), 138'd0);
    chk("abort_busy", 138'(busy_o), 138'd0);
    sb.delete();
    push_expected(32'h00000077, 32'd2, 2'd0);
    start_run(32'h00000077, 32'd2, 2'd0);
    wait_done(60, "post_abort_done");
    chk("post_abort_count", 138'(vec_count_o), 138'd2);
    chk("post_abort_lcg", 138'(lcg_state_o), 138'(exp_lcg));

    // Reset asserted mid-fill
    push_expected(32'd5, 32'd3, 2'd0);
    start_run(32'd5, 32'd3, 2'd0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vec", vec_o, 138'd0);
    chk("mid_rst_valid", 138'(vec_valid_o), 138'd0);
    chk("mid_rst_busy", 138'(busy_o), 138'd0);
    chk("mid_rst_done", 138'(done_o), 138'd0);
    chk("mid_rst_count", 138'(vec_count_o), 138'd0);
    chk("mid_rst_lcg", 138'(lcg_state_o), 138'hE80AD44B);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
